load_store_unit: RTL and testbench

- Multi-cycle initiator between the CPU memory stage and the word-wide, byte-addressed data memory.
- Handles all RV32I load and store widths: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Memory presents whole words only, so the block performs word alignment, byte-lane extraction with sign/zero extension, and read-modify-write for sub-word stores.
- Returns one response per accepted request over a valid/ready handshake.

---
 rtl/load_store_unit.sv | 195 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store initiator: word alignment, lane extraction/extension and read-modify-write stores.
// Define LSU_MISALIGN_TRAP_EN to report misaligned halfword/word requests as errors.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    localparam int unsigned DW = 32;
    localparam int unsigned HW = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_MERGE  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [2:0] F3_B = 3'b000;
    localparam logic [2:0] F3_H = 3'b001;
    localparam logic [2:0] F3_W = 3'b010;

    logic [1:0]    state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;
    logic [HW-1:0] wdata_q, wdata_d;
    logic          ready_q, ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [DW-1:0] mem_a_q, mem_a_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;
    logic          mem_we_q, mem_we_d;

    logic          bad_req_c;
    logic [7:0]    byte_c;
    logic [HW-1:0] half_c;
    logic [DW-1:0] load_c;
    logic [4:0]    lane_sh_c;
    logic [DW-1:0] mask_c;
    logic [DW-1:0] ins_c;
    logic [DW-1:0] merged_c;

    // Request legality, checked on the unlatched request at accept time
    always_comb begin
        if (req_we) begin
            bad_req_c = !(req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W);
        end else begin
            bad_req_c = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
            bad_req_c = 1'b1;
        end
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) begin
            bad_req_c = 1'b1;
        end
`endif
    end

    // Lane extraction with sign/zero extension; funct3[2] selects unsigned
    always_comb begin
        byte_c = 8'(mem_RD >> {off_q, 3'b000});
        half_c = off_q[1] ? mem_RD[31:16] : mem_RD[15:0];
        case (f3_q[1:0])
            2'b00:   load_c = {{24{byte_c[7] & ~f3_q[2]}}, byte_c};
            2'b01:   load_c = {{16{half_c[15] & ~f3_q[2]}}, half_c};
            default: load_c = mem_RD;
        endcase
    end

    // Sub-word store merge; halfword offset ignores addr[0]
    always_comb begin
        lane_sh_c = f3_q[0] ? {off_q[1], 4'b0000} : {off_q, 3'b000};
        mask_c    = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << lane_sh_c;
        ins_c     = (f3_q[0] ? {16'h0000, wdata_q} : {24'h000000, wdata_q[7:0]}) << lane_sh_c;
        merged_c  = (mem_RD & ~mask_c) | ins_c;
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        mem_a_d      = mem_a_q;
        mem_wd_d     = mem_wd_q;
        mem_we_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata[HW-1:0];
                    mem_a_d = {req_addr[31:2], 2'b00};
                    ready_d = 1'b0;
                    if (bad_req_c) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        rdata_d      = '0;
                        err_d        = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        if (req_we && req_funct3 == F3_W) begin
                            mem_we_d = 1'b1;
                            mem_wd_d = req_wdata;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    rdata_d      = load_c;
                    err_d        = 1'b0;
                end else if (f3_q == F3_W) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    rdata_d      = '0;
                    err_d        = 1'b0;
                end else begin
                    state_d  = ST_MERGE;
                    mem_we_d = 1'b1;
                    mem_wd_d = merged_c;
                end
            end
            ST_MERGE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                rdata_d      = '0;
                err_d        = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            mem_a_q      <= '0;
            mem_wd_q     <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            mem_a_q      <= mem_a_d;
            mem_wd_q     <= mem_wd_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_A      = mem_a_q;
    assign mem_WD     = mem_wd_q;
    assign mem_WE     = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-array memory and a request-level reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_A, mem_WD, mem_RD;
    logic        mem_WE;

    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    // Expectations of the request in flight
    logic        active = 1'b0;
    int          d = 0;
    int          exp_lat;
    logic [31:0] exp_rdata, exp_word;
    logic        exp_err, exp_wr;
    logic [31:0] exp_a;
    logic [31:0] last_rdata;
    logic        last_err;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    assign mem_RD = tb_mem[mem_A[9:2]];
    always @(posedge clk) if (mem_WE) tb_mem[mem_A[9:2]] <= mem_WD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the current request's expectations
    always @(negedge clk) begin
        if (active) begin
            chk("resp_valid", 32'(resp_valid), 32'(d == exp_lat - 1));
            chk("req_ready", 32'(req_ready), 32'(d >= exp_lat));
            chk("mem_WE", 32'(mem_WE), 32'(exp_wr && d == exp_lat - 2));
            if (exp_wr && d == exp_lat - 2) begin
                chk("mem_A", mem_A, exp_a);
                chk("mem_WD", mem_WD, exp_word);
            end
            if (d == exp_lat - 1) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", 32'(resp_err), 32'(exp_err));
                last_rdata = resp_rdata;
                last_err   = resp_err;
            end
            d++;
        end
    end

    // Reference behaviour of one request, from the RV32I access rules
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        logic [31:0] w, b, h;
        int          bs, hs;
        logic        bad;
        w  = ref_mem[addr[9:2]];
        bs = 8 * int'(addr[1:0]);
        hs = addr[1] ? 16 : 0;
        bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) bad = 1'b1;
        if (f3 == 3'd2 && addr[1:0] != 2'b00) bad = 1'b1;
`endif
        exp_a    = {addr[31:2], 2'b00};
        exp_word = w;
        exp_err  = bad;
        exp_wr   = 1'b0;
        exp_rdata = 32'h0;
        if (bad) begin
            exp_lat = 1;
        end else if (!we) begin
            exp_lat = 2;
            b = (w >> bs) & 32'hFF;
            h = (w >> hs) & 32'hFFFF;
            case (f3)
                3'd0:    exp_rdata = (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
                3'd1:    exp_rdata = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
                3'd4:    exp_rdata = b;
                3'd5:    exp_rdata = h;
                default: exp_rdata = w;
            endcase
        end else begin
            exp_wr = 1'b1;
            case (f3)
                3'd0: begin
                    exp_lat  = 3;
                    exp_word = (w & ~(32'hFF << bs)) | ((wd & 32'hFF) << bs);
                end
                3'd1: begin
                    exp_lat  = 3;
                    exp_word = (w & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
                end
                default: begin
                    exp_lat  = 2;
                    exp_word = wd;
                end
            endcase
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        model(we, f3, addr, wd);
        last_rdata = 32'hBAD0_BAD0;
        last_err   = 1'bx;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
        d = 0;
        active = 1'b1;
        repeat (exp_lat + 1) @(negedge clk);
        #1;
        active = 1'b0;
        chk("mem_word", tb_mem[addr[9:2]], exp_word);
        ref_mem[addr[9:2]] = exp_word;
    endtask

    task automatic set_word(input logic [31:0] addr, input logic [31:0] v);
        tb_mem[addr[9:2]]  = v;
        ref_mem[addr[9:2]] = v;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        chk("rst mem_WE", 32'(mem_WE), 32'd0);
        chk("rst mem_A", mem_A, 32'd0);
        chk("rst mem_WD", mem_WD, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        set_word(32'h100, 32'h8899_AABB);
        do_req(1'b0, 3'd0, 32'h103, 32'h0);
        chk("LB 0x103 literal", last_rdata, 32'hFFFF_FF88);
        do_req(1'b0, 3'd4, 32'h103, 32'h0);
        chk("LBU 0x103 literal", last_rdata, 32'h0000_0088);
        do_req(1'b0, 3'd1, 32'h102, 32'h0);
        chk("LH 0x102 literal", last_rdata, 32'hFFFF_8899);
        do_req(1'b0, 3'd2, 32'h100, 32'h0);
        chk("LW 0x100 literal", last_rdata, 32'h8899_AABB);
        do_req(1'b0, 3'd0, 32'h100, 32'h0);
        do_req(1'b0, 3'd4, 32'h101, 32'h0);
        do_req(1'b0, 3'd1, 32'h100, 32'h0);
        do_req(1'b0, 3'd5, 32'h102, 32'h0);
        do_req(1'b0, 3'd5, 32'h101, 32'h0);

        do_req(1'b1, 3'd0, 32'h101, 32'h1234_5677);
        chk("SB 0x101 literal", tb_mem[8'h40], 32'h8899_77BB);
        set_word(32'h100, 32'h8899_AABB);
        do_req(1'b1, 3'd1, 32'h102, 32'h0000_CAFE);
        chk("SH 0x102 literal", tb_mem[8'h40], 32'hCAFE_AABB);
        do_req(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF);
        chk("SW 0x100 literal", tb_mem[8'h40], 32'hDEAD_BEEF);
        do_req(1'b1, 3'd0, 32'h108, 32'h0000_00A5);
        do_req(1'b1, 3'd1, 32'h10C, 32'h0000_1234);

        do_req(1'b0, 3'd3, 32'h100, 32'h0);
        chk("load f3=011 err", 32'(last_err), 32'd1);
        chk("load f3=011 rdata", last_rdata, 32'd0);
        do_req(1'b1, 3'd4, 32'h100, 32'h1111_1111);
        chk("store f3=100 err", 32'(last_err), 32'd1);
        chk("store f3=100 mem", tb_mem[8'h40], 32'hDEAD_BEEF);

        set_word(32'h100, 32'h8899_AABB);
        do_req(1'b0, 3'd2, 32'h102, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("LW 0x102 err", 32'(last_err), 32'd1);
        chk("LW 0x102 rdata", last_rdata, 32'd0);
`else
        chk("LW 0x102 err", 32'(last_err), 32'd0);
        chk("LW 0x102 rdata", last_rdata, 32'h8899_AABB);
`endif

        // Store aborted by reset in MERGE
        set_word(32'h100, 32'h8899_AABB);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h101; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort mem_WE in MERGE", 32'(mem_WE), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort mem_WE drop", 32'(mem_WE), 32'd0);
        chk("abort req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort resp_valid", 32'(resp_valid), 32'd0);
            chk("abort ready", 32'(req_ready), 32'd1);
        end
        chk("abort mem unchanged", tb_mem[8'h40], 32'h8899_AABB);

        do_req(1'b0, 3'd2, 32'h100, 32'h0);
        chk("post-abort LW", last_rdata, 32'h8899_AABB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
